agu_exec: RTL and testbench
===========================

AGU_EXEC -- requirements
Module: agu_exec

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/address width.
REQ-002 SHALL have parameter AQ_DEPTH, default 4, address-queue entries.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  pipeline flush.
REQ-006 SHALL have ports valid_op_awake / Pa_awake / Imm_awake / tag_ROB_awake  input  1/5/5/5  issued op from the AGU reservation station.
REQ-007 SHALL have port freeze_back  output  1  back-pressure to the reservation station.
REQ-008 SHALL have ports Pa_rf  output  5  and data_rf  input  DATA_W  physical-register-file read port, combinational read.
REQ-009 SHALL have ports Pw_Result_add/valid_Result_add/data_Result_add, Pw_Result_mul/valid_Result_mul/data_Result_mul, Pw_Result_ls/valid_Result_ls/mode_ls/data_Result_ls  input  5/1/DATA_W (+1 mode)  result broadcasts.
REQ-010 SHALL have ports valid_addr / addr / tag_ROB_addr  output  1/DATA_W/5  address to the load/store unit.
REQ-011 SHALL have port ready_lsq  input  1  load/store unit accepts head entry.

Function
REQ-012 Pa_rf SHALL equal Pa_awake combinationally.
REQ-013 Operand SHALL be the first match of: add broadcast (valid_Result_add and Pw_Result_add==Pa_awake), mul broadcast, ls broadcast (valid_Result_ls and mode_ls==1), else data_rf.
REQ-014 addr SHALL be operand + sign-extended Imm_awake, modulo 2^DATA_W.
REQ-015 Every cycle with valid_op_awake=1 and flush=0 SHALL push {addr, tag_ROB_awake} into the queue at that edge, regardless of freeze_back.
REQ-016 Queue SHALL be FIFO; head drives valid_addr=1, addr, tag_ROB_addr when non-empty; valid_addr=0 with addr=0, tag_ROB_addr=0 when empty.
REQ-017 Head SHALL pop at an edge where valid_addr=1 and ready_lsq=1.
REQ-018 Simultaneous push and pop SHALL keep count unchanged; push into empty queue SHALL appear on outputs the next cycle (1-cycle latency, no bypass).
REQ-019 freeze_back SHALL be 1 exactly when registered count >= AQ_DEPTH-1, reserving one slot for the op already latched in the reservation station output.
REQ-020 A push when count==AQ_DEPTH SHALL never occur under REQ-019; if it does, the push SHALL be dropped and count SHALL stay AQ_DEPTH.
REQ-021 Read/write pointers SHALL wrap modulo AQ_DEPTH; count SHALL range 0..AQ_DEPTH.
REQ-022 flush=1 SHALL empty the queue at that edge, discard any concurrent push and pop, and outputs SHALL show empty the next cycle.

Reset
REQ-023 rst=1 SHALL immediately clear pointers, count and entries; valid_addr=0, addr=0, tag_ROB_addr=0, freeze_back=0.
REQ-024 rst asserted mid-operation SHALL discard all queued entries; no entry SHALL reappear after release.

Structure
REQ-025 Shared package SHALL hold DATA_W, PREG_W=5, TAG_W=5, AQ_DEPTH and packed struct agu_entry {addr, tag_ROB}.
REQ-026 Queue SHALL be sub-module agu_addr_queue (push/pop/flush, count, full-minus-one flag); operand select and adder stay in agu_exec.

Verification
REQ-027 Pa_awake=3, data_rf=0x100, Imm=5'h1F, ready_lsq=1 -> next cycle valid_addr=1, addr=0xFF, tag echoed.
REQ-028 Same cycle Pw_Result_add=3 data 0x200 and Pw_Result_mul=3 data 0x300 -> addr=0x200+sext(Imm) (add wins); ls with mode_ls=0 -> ignored.
REQ-029 ready_lsq=0, four back-to-back ops -> freeze_back=1 once count=3, fourth op accepted, count=4, order preserved on release.
REQ-030 count=2, push and pop same cycle repeatedly for 10 cycles -> count stays 2, pointers wrap, FIFO order intact.
REQ-031 Queue holding 3 entries, flush=1 with valid_op_awake=1 -> next cycle valid_addr=0, freeze_back=0.
REQ-032 rst pulsed asynchronously between edges with 2 entries queued -> outputs zero immediately; after release valid_addr stays 0 until new push.

Source files
------------

// File: rtl/agu_exec_pkg.sv
// Shared AGU types and sizes: operand width, register/tag widths, address-queue depth.
// Pure definitions; no logic, latency or backpressure of its own.
package agu_exec_pkg;
    localparam int DATA_W   = 32;
    localparam int PREG_W   = 5;
    localparam int TAG_W    = 5;
    localparam int IMM_W    = 5;
    localparam int AQ_DEPTH = 4;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [TAG_W-1:0]  tag_ROB;
    } agu_entry;
endpackage

// File: rtl/agu_exec_if.sv
// AGU bundle: reservation-station issue, PRF read port, result broadcasts, LSQ address port.
// Wiring only; slave is the AGU side, master is the environment side.
interface agu_exec_if #(
    parameter int DATA_W = agu_exec_pkg::DATA_W
);
    import agu_exec_pkg::*;

    logic               flush;
    logic               valid_op_awake;
    logic [PREG_W-1:0]  Pa_awake;
    logic [IMM_W-1:0]   Imm_awake;
    logic [TAG_W-1:0]   tag_ROB_awake;
    logic               freeze_back;
    logic [PREG_W-1:0]  Pa_rf;
    logic [DATA_W-1:0]  data_rf;
    logic [PREG_W-1:0]  Pw_Result_add;
    logic               valid_Result_add;
    logic [DATA_W-1:0]  data_Result_add;
    logic [PREG_W-1:0]  Pw_Result_mul;
    logic               valid_Result_mul;
    logic [DATA_W-1:0]  data_Result_mul;
    logic [PREG_W-1:0]  Pw_Result_ls;
    logic               valid_Result_ls;
    logic               mode_ls;
    logic [DATA_W-1:0]  data_Result_ls;
    logic               valid_addr;
    logic [DATA_W-1:0]  addr;
    logic [TAG_W-1:0]   tag_ROB_addr;
    logic               ready_lsq;

    modport slave (
        input  flush, valid_op_awake, Pa_awake, Imm_awake, tag_ROB_awake, data_rf,
               Pw_Result_add, valid_Result_add, data_Result_add,
               Pw_Result_mul, valid_Result_mul, data_Result_mul,
               Pw_Result_ls, valid_Result_ls, mode_ls, data_Result_ls, ready_lsq,
        output freeze_back, Pa_rf, valid_addr, addr, tag_ROB_addr
    );

    modport master (
        output flush, valid_op_awake, Pa_awake, Imm_awake, tag_ROB_awake, data_rf,
               Pw_Result_add, valid_Result_add, data_Result_add,
               Pw_Result_mul, valid_Result_mul, data_Result_mul,
               Pw_Result_ls, valid_Result_ls, mode_ls, data_Result_ls, ready_lsq,
        input  freeze_back, Pa_rf, valid_addr, addr, tag_ROB_addr
    );
endinterface

// File: rtl/agu_addr_queue.sv
// Address FIFO; push to head-visible in 1 cycle, no bypass; flush empties at the edge.
// Push while full is dropped; almost_full (count >= DEPTH-1) is the upstream stall.
module agu_addr_queue #(
    parameter int DEPTH = agu_exec_pkg::AQ_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  agu_exec_pkg::agu_entry       push_dat,
    input  logic                         pop,
    output agu_exec_pkg::agu_entry       head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full
);
    import agu_exec_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    agu_entry           mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Stale entries stay in mem after pop/flush, so mask the head when empty.
    assign head_dat    = (count != '0) ? mem[rd_ptr] : '0;
    assign almost_full = (count >= CNT_W'(DEPTH - 1));
endmodule

// File: rtl/agu_exec.sv
// AGU execute: forwarded/PRF operand + sign-extended imm, queued toward the LSQ (1-cycle latency).
// freeze_back stalls the reservation station at count >= AQ_DEPTH-1; LSQ pops via ready_lsq.
module agu_exec #(
    parameter int DATA_W   = agu_exec_pkg::DATA_W,
    parameter int AQ_DEPTH = agu_exec_pkg::AQ_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    agu_exec_if.slave  bus
);
    import agu_exec_pkg::*;

    localparam int CNT_W = $clog2(AQ_DEPTH + 1);

    logic [DATA_W-1:0]  operand;
    logic [DATA_W-1:0]  imm_ext;
    logic [DATA_W-1:0]  addr_calc;
    agu_entry           push_entry;
    agu_entry           head_entry;
    logic [CNT_W-1:0]   aq_count;
    logic               aq_almost_full;

    assign bus.Pa_rf = bus.Pa_awake;

    // Bypass priority add > mul > ls-load; ls results only carry data when mode_ls=1.
    always_comb begin
        operand = bus.data_rf;
        if (bus.valid_Result_add && (bus.Pw_Result_add == bus.Pa_awake))
            operand = bus.data_Result_add;
        else if (bus.valid_Result_mul && (bus.Pw_Result_mul == bus.Pa_awake))
            operand = bus.data_Result_mul;
        else if (bus.valid_Result_ls && bus.mode_ls && (bus.Pw_Result_ls == bus.Pa_awake))
            operand = bus.data_Result_ls;
    end

    assign imm_ext    = {{(DATA_W-IMM_W){bus.Imm_awake[IMM_W-1]}}, bus.Imm_awake};
    assign addr_calc  = operand + imm_ext;
    assign push_entry = '{addr: addr_calc, tag_ROB: bus.tag_ROB_awake};

    agu_addr_queue #(
        .DEPTH (AQ_DEPTH)
    ) u_aq (
        .clk         (clk),
        .rst         (rst),
        .flush       (bus.flush),
        .push        (bus.valid_op_awake),
        .push_dat    (push_entry),
        .pop         (bus.ready_lsq),
        .head_dat    (head_entry),
        .count       (aq_count),
        .almost_full (aq_almost_full)
    );

    assign bus.valid_addr   = (aq_count != '0);
    assign bus.addr         = head_entry.addr;
    assign bus.tag_ROB_addr = head_entry.tag_ROB;
    assign bus.freeze_back  = aq_almost_full;
endmodule

// File: tb/tb_agu_exec.sv
// Directed bench for agu_exec: forwarding priority, queue fill/drain, wrap, flush, async reset.
module tb_agu_exec;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    agu_exec_if #(.DATA_W(32)) bus();

    agu_exec #(.DATA_W(32), .AQ_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_bcast();
        bus.valid_Result_add = 1'b0; bus.Pw_Result_add = '0; bus.data_Result_add = '0;
        bus.valid_Result_mul = 1'b0; bus.Pw_Result_mul = '0; bus.data_Result_mul = '0;
        bus.valid_Result_ls  = 1'b0; bus.Pw_Result_ls  = '0; bus.data_Result_ls  = '0;
        bus.mode_ls = 1'b0;
    endtask

    // Present one op for exactly one edge; valid_op_awake is left high for back-to-back use.
    task automatic issue(input logic [4:0] pa, input logic [4:0] imm, input logic [4:0] tag,
                         input logic [31:0] rf);
        bus.valid_op_awake = 1'b1;
        bus.Pa_awake       = pa;
        bus.Imm_awake      = imm;
        bus.tag_ROB_awake  = tag;
        bus.data_rf        = rf;
        step();
    endtask

    logic [4:0]  exp_tag  [4];
    logic [31:0] exp_addr [4];
    logic        exp_frz  [4];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.valid_op_awake = 1'b0;
        bus.Pa_awake = '0;
        bus.Imm_awake = '0;
        bus.tag_ROB_awake = '0;
        bus.data_rf = '0;
        bus.ready_lsq = 1'b0;
        clr_bcast();
        #3;
        chk("rst_valid", bus.valid_addr, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_tag", bus.tag_ROB_addr, 0);
        chk("rst_freeze", bus.freeze_back, 0);
        step();
        step();
        rst = 1'b0;

        // Basic PRF operand with negative immediate: 0x100 + (-1)
        bus.ready_lsq = 1'b1;
        bus.valid_op_awake = 1'b1;
        bus.Pa_awake = 5'd3;
        bus.data_rf = 32'h100;
        bus.Imm_awake = 5'h1F;
        bus.tag_ROB_awake = 5'd7;
        #1;
        chk("pa_rf", bus.Pa_rf, 3);
        chk("no_bypass_before_edge", bus.valid_addr, 0);
        step();
        bus.valid_op_awake = 1'b0;
        chk("t1_valid", bus.valid_addr, 1);
        chk("t1_addr", bus.addr, 32'hFF);
        chk("t1_tag", bus.tag_ROB_addr, 7);
        chk("t1_freeze", bus.freeze_back, 0);
        step();
        chk("t1_popped", bus.valid_addr, 0);
        chk("t1_empty_addr", bus.addr, 0);

        // Forwarding priority and fill to full with the LSQ stalled
        bus.ready_lsq = 1'b0;
        bus.valid_Result_add = 1'b1; bus.Pw_Result_add = 5'd3; bus.data_Result_add = 32'h200;
        bus.valid_Result_mul = 1'b1; bus.Pw_Result_mul = 5'd3; bus.data_Result_mul = 32'h300;
        issue(5'd3, 5'h1F, 5'd1, 32'h100);
        clr_bcast();
        chk("fill1_freeze", bus.freeze_back, 0);
        bus.valid_Result_add = 1'b1; bus.Pw_Result_add = 5'd4; bus.data_Result_add = 32'h999;
        bus.valid_Result_mul = 1'b1; bus.Pw_Result_mul = 5'd3; bus.data_Result_mul = 32'h300;
        issue(5'd3, 5'd2, 5'd2, 32'h100);
        clr_bcast();
        chk("fill2_freeze", bus.freeze_back, 0);
        bus.valid_Result_ls = 1'b1; bus.Pw_Result_ls = 5'd3; bus.data_Result_ls = 32'h400;
        bus.mode_ls = 1'b0;
        issue(5'd3, 5'd0, 5'd3, 32'h100);
        clr_bcast();
        chk("fill3_freeze", bus.freeze_back, 1);
        bus.valid_Result_ls = 1'b1; bus.Pw_Result_ls = 5'd3; bus.data_Result_ls = 32'h400;
        bus.mode_ls = 1'b1;
        issue(5'd3, 5'h10, 5'd4, 32'h100);
        clr_bcast();
        chk("fill4_freeze", bus.freeze_back, 1);
        issue(5'd3, 5'd0, 5'd5, 32'h555);
        bus.valid_op_awake = 1'b0;

        exp_tag  = '{5'd1, 5'd2, 5'd3, 5'd4};
        exp_addr = '{32'h1FF, 32'h302, 32'h100, 32'h3F0};
        exp_frz  = '{1'b1, 1'b1, 1'b0, 1'b0};
        bus.ready_lsq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_valid", i), bus.valid_addr, 1);
            chk($sformatf("drain%0d_tag", i), bus.tag_ROB_addr, exp_tag[i]);
            chk($sformatf("drain%0d_addr", i), bus.addr, exp_addr[i]);
            chk($sformatf("drain%0d_freeze", i), bus.freeze_back, exp_frz[i]);
            step();
        end
        chk("drain_empty", bus.valid_addr, 0);

        // Steady push+pop at count 2 across pointer wrap
        bus.ready_lsq = 1'b0;
        issue(5'd1, 5'd0, 5'd10, 32'h100A);
        issue(5'd1, 5'd0, 5'd11, 32'h100B);
        bus.ready_lsq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("wrap%0d_tag", i), bus.tag_ROB_addr, 32'(10 + i));
            chk($sformatf("wrap%0d_addr", i), bus.addr, 32'h1000 + 32'(10 + i));
            chk($sformatf("wrap%0d_freeze", i), bus.freeze_back, 0);
            issue(5'd1, 5'd0, 5'(12 + i), 32'h1000 + 32'(12 + i));
        end
        bus.valid_op_awake = 1'b0;
        chk("wrap_tail0_tag", bus.tag_ROB_addr, 20);
        step();
        chk("wrap_tail1_tag", bus.tag_ROB_addr, 21);
        chk("wrap_tail1_addr", bus.addr, 32'h1015);
        step();
        chk("wrap_empty", bus.valid_addr, 0);

        // Flush with three queued and a concurrent push
        bus.ready_lsq = 1'b0;
        issue(5'd1, 5'd0, 5'd1, 32'h1);
        issue(5'd1, 5'd0, 5'd2, 32'h2);
        issue(5'd1, 5'd0, 5'd3, 32'h3);
        chk("preflush_freeze", bus.freeze_back, 1);
        bus.flush = 1'b1;
        bus.ready_lsq = 1'b1;
        issue(5'd1, 5'd0, 5'd9, 32'h9);
        bus.flush = 1'b0;
        bus.valid_op_awake = 1'b0;
        chk("flush_valid", bus.valid_addr, 0);
        chk("flush_freeze", bus.freeze_back, 0);
        chk("flush_addr", bus.addr, 0);
        step();
        chk("flush_push_dropped", bus.valid_addr, 0);

        // Asynchronous reset between edges with two entries queued
        bus.ready_lsq = 1'b0;
        issue(5'd1, 5'd0, 5'd25, 32'h25);
        issue(5'd1, 5'd0, 5'd26, 32'h26);
        bus.valid_op_awake = 1'b0;
        chk("prerst_tag", bus.tag_ROB_addr, 25);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", bus.valid_addr, 0);
        chk("arst_addr", bus.addr, 0);
        chk("arst_tag", bus.tag_ROB_addr, 0);
        chk("arst_freeze", bus.freeze_back, 0);
        #2 rst = 1'b0;
        step();
        step();
        chk("postrst_valid", bus.valid_addr, 0);
        bus.ready_lsq = 1'b1;
        issue(5'd1, 5'd0, 5'd30, 32'h30);
        bus.valid_op_awake = 1'b0;
        chk("postrst_new_valid", bus.valid_addr, 1);
        chk("postrst_new_tag", bus.tag_ROB_addr, 30);
        chk("postrst_new_addr", bus.addr, 32'h30);
        step();
        chk("postrst_drained", bus.valid_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
